// File: rtl/alu_result_uart_tx.sv
// Serializes a captured ALU result onto a UART TX line as one 8N1 frame, LSB first.
// Define ALU_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module alu_result_uart_tx #(
    parameter int N         = 5,
    parameter int DATA_BITS = 8,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_result,
    input  logic         i_send,
    output logic         o_tx,
    output logic         o_busy,
    output logic         o_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    generate
        if (N > DATA_BITS) begin : g_width_check
            $error("alu_result_uart_tx: N must not exceed DATA_BITS");
        end
        if (CLKS_PER_BIT < 2) begin : g_baud_check
            $error("alu_result_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef ALU_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [IW-1:0]          bit_idx_r;
    logic [DATA_BITS-1:0]   shreg_r;
    logic                   tx_r;
    logic                   busy_r;
    logic                   done_r;
`ifdef ALU_TX_PARITY_EN
    logic                   parity_r;
`endif

    assign o_tx   = tx_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

    // Frame sequencer; every output is set one cycle ahead so the line value is registered.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= '0;
            shreg_r   <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r    <= 1'b0;
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                    if (i_send) begin
                        shreg_r  <= DATA_BITS'(i_result);
`ifdef ALU_TX_PARITY_EN
                        parity_r <= ^i_result;
`endif
                        state_r  <= S_START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        tx_r     <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= '0;
                        bit_idx_r <= '0;
                        state_r   <= S_DATA;
                        tx_r      <= shreg_r[0];
                    end else begin
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (bit_idx_r == IDX_LAST) begin
`ifdef ALU_TX_PARITY_EN
                            state_r <= S_PARITY;
                            tx_r    <= parity_r;
`else
                            state_r <= S_STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + IW'(1);
                            shreg_r   <= shreg_r >> 1;
                            tx_r      <= shreg_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`ifdef ALU_TX_PARITY_EN
                S_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= S_STOP;
                        tx_r    <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // o_done is raised one cycle early so it coincides with the last stop cycle.
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        done_r  <= (cnt_r == CNT_PRE);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
